// File: rtl/exec_cc_mreg_pkg.sv
// rtl/exec_cc_mreg_pkg.sv - Y86-64 icode, condition, status and register-ID constants
package exec_cc_mreg_pkg;

   // Instruction codes
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // Status codes; SBUB marks a pipeline bubble
   localparam logic [2:0] SBUB = 3'd0;
   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   // "No register" for the default 4-bit register-ID width
   localparam logic [3:0] RNONE = 4'hF;

   // Condition selectors shared by jXX and cmovXX
   typedef enum logic [3:0] {
      C_YES = 4'd0,
      C_LE  = 4'd1,
      C_L   = 4'd2,
      C_E   = 4'd3,
      C_NE  = 4'd4,
      C_GE  = 4'd5,
      C_G   = 4'd6
   } cond_t;

   // Condition-code register layout, {ZF,SF,OF}
   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } cc_t;

endpackage

// File: rtl/exec_cc_mreg_cond_eval.sv
// rtl/exec_cc_mreg_cond_eval.sv - jXX/cmovXX condition evaluation from CC and ifun
module exec_cc_mreg_cond_eval
   import exec_cc_mreg_pkg::*;
(
   input  cc_t        cc,
   input  logic [3:0] ifun,
   output logic       cnd
);

   logic lt;

   assign lt = cc.sf ^ cc.of;

   // Decode the selector; unassigned selectors never fire
   always_comb begin
      cnd = 1'b0;
      case (ifun)
         C_YES:   cnd = 1'b1;
         C_LE:    cnd = lt | cc.zf;
         C_L:     cnd = lt;
         C_E:     cnd = cc.zf;
         C_NE:    cnd = ~cc.zf;
         C_GE:    cnd = ~lt;
         C_G:     cnd = ~lt & ~cc.zf;
         default: cnd = 1'b0;
      endcase
   end

endmodule

// File: rtl/exec_cc_mreg.sv
// rtl/exec_cc_mreg.sv - execute-stage flags, CC register, condition eval and E->M register
module exec_cc_mreg
   import exec_cc_mreg_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int REG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             e_valid,
   input  logic [3:0]       e_icode,
   input  logic [3:0]       e_ifun,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_ovf,
   input  logic [WIDTH-1:0] e_valA,
   input  logic [REG_W-1:0] e_dstE,
   input  logic [REG_W-1:0] e_dstM,
   input  logic [2:0]       e_stat,
   input  logic             m_exc,
   input  logic             w_exc,
   input  logic             M_stall,
   input  logic             M_bubble,
   output logic [2:0]       cc,
   output logic             e_cnd,
   output logic             M_valid,
   output logic [3:0]       M_icode,
   output logic             M_cnd,
   output logic [WIDTH-1:0] M_valE,
   output logic [WIDTH-1:0] M_valA,
   output logic [REG_W-1:0] M_dstE,
   output logic [REG_W-1:0] M_dstM,
   output logic [2:0]       M_stat
);

   localparam logic [REG_W-1:0] REG_NONE = '1;

   cc_t              cc_q;
   cc_t              cc_new;
   logic             set_cc;
   logic [REG_W-1:0] dstE_eff;

   // Flags straight from the ALU; overflow is trusted as supplied
   assign cc_new.zf = (alu_out == '0);
   assign cc_new.sf = alu_out[WIDTH-1];
   assign cc_new.of = alu_ovf;

   // Any exception downstream freezes CC so younger OPq cannot leak state
   assign set_cc = e_valid & (e_icode == IOPQ) & ~m_exc & ~w_exc & ~M_stall;

   assign cc = cc_q;

   exec_cc_mreg_cond_eval u_cond_eval (
      .cc   (cc_q),
      .ifun (e_ifun),
      .cnd  (e_cnd)
   );

   // A cmov whose condition fails must not write its destination
   assign dstE_eff = ((e_icode == IRRMOVQ) && !e_cnd) ? REG_NONE : e_dstE;

   // Condition-code register, ZF set out of reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cc_q <= 3'b100;
      end else if (set_cc) begin
         cc_q <= cc_new;
      end
   end

   // E->M register: reset > stall (hold) > bubble or empty E (NOP) > load
   always_ff @(posedge clk) begin
      if (!rst_n || (!M_stall && (M_bubble || !e_valid))) begin
         M_valid <= 1'b0;
         M_icode <= INOP;
         M_cnd   <= 1'b0;
         M_valE  <= '0;
         M_valA  <= '0;
         M_dstE  <= REG_NONE;
         M_dstM  <= REG_NONE;
         M_stat  <= SBUB;
      end else if (!M_stall) begin
         M_valid <= 1'b1;
         M_icode <= e_icode;
         M_cnd   <= e_cnd;
         M_valE  <= alu_out;
         M_valA  <= e_valA;
         M_dstE  <= dstE_eff;
         M_dstM  <= e_dstM;
         M_stat  <= e_stat;
      end
   end

endmodule

// File: tb/tb_exec_cc_mreg.sv
// tb/tb_exec_cc_mreg.sv - randomized self-checking bench for exec_cc_mreg
module tb_exec_cc_mreg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        e_valid;
   logic [3:0]  e_icode;
   logic [3:0]  e_ifun;
   logic [63:0] alu_out;
   logic        alu_ovf;
   logic [63:0] e_valA;
   logic [3:0]  e_dstE;
   logic [3:0]  e_dstM;
   logic [2:0]  e_stat;
   logic        m_exc;
   logic        w_exc;
   logic        M_stall;
   logic        M_bubble;
   logic [2:0]  cc;
   logic        e_cnd;
   logic        M_valid;
   logic [3:0]  M_icode;
   logic        M_cnd;
   logic [63:0] M_valE;
   logic [63:0] M_valA;
   logic [3:0]  M_dstE;
   logic [3:0]  M_dstM;
   logic [2:0]  M_stat;

   int checks   = 0;
   int failures = 0;

   // Reference state
   logic [2:0]  r_cc;
   logic        r_valid;
   logic [3:0]  r_icode;
   logic        r_cnd;
   logic [63:0] r_valE;
   logic [63:0] r_valA;
   logic [3:0]  r_dstE;
   logic [3:0]  r_dstM;
   logic [2:0]  r_stat;
   bit          known = 0;

   exec_cc_mreg #(.WIDTH(64), .REG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
      .alu_out(alu_out), .alu_ovf(alu_ovf), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
      .e_stat(e_stat), .m_exc(m_exc), .w_exc(w_exc), .M_stall(M_stall), .M_bubble(M_bubble),
      .cc(cc), .e_cnd(e_cnd), .M_valid(M_valid), .M_icode(M_icode), .M_cnd(M_cnd),
      .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_stat(M_stat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Signed-comparison view of the previous OPq: lt means "result < 0" after overflow correction
   function automatic logic cond_ref(input logic [2:0] c, input logic [3:0] f);
      logic z, lt;
      logic [15:0] table_bits;
      z  = c[2];
      lt = (c[1] != c[0]);
      table_bits = '0;
      table_bits[0] = 1'b1;
      table_bits[1] = lt || z;
      table_bits[2] = lt;
      table_bits[3] = z;
      table_bits[4] = !z;
      table_bits[5] = !lt;
      table_bits[6] = !lt && !z;
      return table_bits[f];
   endfunction

   task automatic check_outputs();
      chk("cc", {61'd0, cc}, {61'd0, r_cc});
      chk("M_valid", {63'd0, M_valid}, {63'd0, r_valid});
      chk("M_icode", {60'd0, M_icode}, {60'd0, r_icode});
      chk("M_cnd", {63'd0, M_cnd}, {63'd0, r_cnd});
      chk("M_valE", M_valE, r_valE);
      chk("M_valA", M_valA, r_valA);
      chk("M_dstE", {60'd0, M_dstE}, {60'd0, r_dstE});
      chk("M_dstM", {60'd0, M_dstM}, {60'd0, r_dstM});
      chk("M_stat", {61'd0, M_stat}, {61'd0, r_stat});
   endtask

   // One clock: check e_cnd, advance the model with the applied inputs, check registered outputs
   task automatic step();
      logic c;
      #1;
      c = cond_ref(r_cc, e_ifun);
      if (known) chk("e_cnd", {63'd0, e_cnd}, {63'd0, c});
      @(posedge clk);
      if (!rst_n) begin
         r_cc = 3'b100;
         r_valid = 0; r_icode = 4'h1; r_cnd = 0; r_valE = 0; r_valA = 0;
         r_dstE = 4'hF; r_dstM = 4'hF; r_stat = 3'd0;
         known = 1;
      end else begin
         if (e_valid && e_icode == 4'h6 && !m_exc && !w_exc && !M_stall)
            r_cc = {alu_out == 64'd0, alu_out[63], alu_ovf};
         if (M_stall) begin
            // hold everything
         end else if (M_bubble || !e_valid) begin
            r_valid = 0; r_icode = 4'h1; r_cnd = 0; r_valE = 0; r_valA = 0;
            r_dstE = 4'hF; r_dstM = 4'hF; r_stat = 3'd0;
         end else begin
            r_valid = 1; r_icode = e_icode; r_cnd = c; r_valE = alu_out; r_valA = e_valA;
            r_dstE = (e_icode == 4'h2 && !c) ? 4'hF : e_dstE;
            r_dstM = e_dstM; r_stat = e_stat;
         end
      end
      @(negedge clk);
      if (known) check_outputs();
   endtask

   task automatic set_e(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] alu, input logic ovf, input logic [3:0] dste);
      e_valid = v; e_icode = ic; e_ifun = fn; alu_out = alu; alu_ovf = ovf; e_dstE = dste;
      e_valA = {$urandom, $urandom}; e_dstM = 4'($urandom); e_stat = 3'd1;
   endtask

   task automatic expect_cnd(input logic [3:0] fn, input logic exp, input string tag);
      set_e(1, 4'h7, fn, 64'd0, 0, 4'hF);
      #1;
      chk(tag, {63'd0, e_cnd}, {63'd0, exp});
   endtask

   initial begin
      rst_n = 0; M_stall = 1; M_bubble = 0; m_exc = 0; w_exc = 0;
      set_e(1, 4'h6, 4'h0, 64'h1234, 1, 4'h2);

      // Reset under stall
      step(); step();
      chk("rst_cc", {61'd0, cc}, 64'd4);
      chk("rst_icode", {60'd0, M_icode}, 64'd1);
      chk("rst_stat", {61'd0, M_stat}, 64'd0);
      chk("rst_dstE", {60'd0, M_dstE}, 64'hF);

      // Nonzero positive, then subq 5-5
      rst_n = 1; M_stall = 0;
      set_e(1, 4'h6, 4'h1, 64'd7, 0, 4'h3); step();
      chk("pos_cc", {61'd0, cc}, 64'd0);
      set_e(1, 4'h6, 4'h1, 64'd0, 0, 4'h3); step();
      chk("zero_cc", {61'd0, cc}, 64'd4);
      expect_cnd(4'h4, 0, "jne_after_zero");
      expect_cnd(4'h3, 1, "je_after_zero");
      step();

      // Negative with overflow -> 011
      set_e(1, 4'h6, 4'h0, 64'h8000_0000_0000_0000, 1, 4'h1); step();
      chk("ovf_cc", {61'd0, cc}, 64'd3);
      expect_cnd(4'h2, 0, "jl_ovf");
      expect_cnd(4'h1, 0, "jle_ovf");
      expect_cnd(4'h5, 1, "jge_ovf");
      step();

      // cmovg with cc=010 (not taken), then cc=000 (taken)
      set_e(1, 4'h6, 4'h1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 4'h1); step();
      chk("neg_cc", {61'd0, cc}, 64'd2);
      set_e(1, 4'h2, 4'h6, 64'hABCD, 0, 4'h3); step();
      chk("cmovg_nt_dstE", {60'd0, M_dstE}, 64'hF);
      chk("cmovg_nt_valE", M_valE, 64'hABCD);
      set_e(1, 4'h6, 4'h1, 64'd1, 0, 4'h1); step();
      set_e(1, 4'h2, 4'h6, 64'h55, 0, 4'h3); step();
      chk("cmovg_t_dstE", {60'd0, M_dstE}, 64'd3);

      // Exceptions freeze CC
      m_exc = 1; set_e(1, 4'h6, 4'h1, 64'd0, 0, 4'h1); step();
      chk("mexc_cc", {61'd0, cc}, 64'd0);
      m_exc = 0; w_exc = 1; step();
      chk("wexc_cc", {61'd0, cc}, 64'd0);
      w_exc = 0;

      // Stall holds CC and M for two cycles
      set_e(1, 4'h6, 4'h0, 64'h42, 0, 4'h5); step();
      M_stall = 1; set_e(1, 4'h6, 4'h0, 64'd0, 1, 4'h6); step(); step();
      chk("stall_cc", {61'd0, cc}, 64'd0);
      chk("stall_valE", M_valE, 64'h42);

      // Stall and bubble together: hold; bubble alone: NOP
      M_bubble = 1; step();
      chk("stallbub_valid", {63'd0, M_valid}, 64'd1);
      M_stall = 0; step();
      chk("bub_valid", {63'd0, M_valid}, 64'd0);
      chk("bub_icode", {60'd0, M_icode}, 64'd1);
      M_bubble = 0;

      // Reset during a stall
      set_e(1, 4'h6, 4'h0, 64'h8000_0000_0000_0001, 0, 4'h2); step();
      M_stall = 1; rst_n = 0; step();
      chk("rststall_cc", {61'd0, cc}, 64'd4);
      chk("rststall_stat", {61'd0, M_stat}, 64'd0);
      rst_n = 1; M_stall = 0;

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic [3:0] ic;
         logic [63:0] alu;
         int sel;
         sel = $urandom_range(0, 9);
         ic = (sel < 4) ? 4'h6 : (sel < 6) ? 4'h2 : (sel < 8) ? 4'h7 : 4'($urandom_range(0, 11));
         sel = $urandom_range(0, 4);
         alu = (sel == 0) ? 64'd0 : (sel == 1) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
         set_e($urandom_range(0, 7) != 0, ic, 4'($urandom_range(0, 8)), alu, $urandom_range(0, 3) == 0,
               4'($urandom));
         e_stat   = 3'($urandom_range(0, 4));
         rst_n    = ($urandom_range(0, 49) != 0);
         M_stall  = ($urandom_range(0, 5) == 0);
         M_bubble = ($urandom_range(0, 5) == 0);
         m_exc    = ($urandom_range(0, 7) == 0);
         w_exc    = ($urandom_range(0, 7) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
